// File: rtl/pca_regs_pkg.sv
// Shared register-map constants and types for the PCA-style LED controller.
// Contents:
//   register ids   - MODE1, LED_BASE, ALL_LED_BASE, PRE_SCALE
//   geometry       - LED_STRIDE (registers per channel), NUM_CHANNELS
//   state_e        - write arbiter states (IDLE / FANOUT)
//   GRANT_A/B      - encoding of the arbiter's last_grant flop
//   in_all_led()   - true when an id addresses one of the four ALL_LED registers
package pca_regs_pkg;

    localparam logic [7:0] MODE1        = 8'h00;
    localparam logic [7:0] LED_BASE     = 8'h06;
    localparam int         LED_STRIDE   = 4;
    localparam logic [7:0] ALL_LED_BASE = 8'hFA;
    localparam logic [7:0] PRE_SCALE    = 8'hFE;
    localparam int         NUM_CHANNELS = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        FANOUT = 1'b1
    } state_e;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    // ALL_LED block is four consecutive ids starting at base.
    function automatic logic in_all_led(input logic [7:0] id, input logic [7:0] base);
        logic [7:0] rel;
        rel = id - base;
        return (id >= base) && (rel < 8'd4);
    endfunction

endpackage

// File: rtl/register_write_arbiter_rr_grant2.sv
// Two-input round-robin grant.
// Ports:
//   valid_a, valid_b - request lines
//   last_grant       - requester granted most recently (GRANT_A / GRANT_B)
//   enable           - when low, nothing is granted
//   grant            - one-hot grant, bit 0 = A, bit 1 = B
module rr_grant2
    import pca_regs_pkg::*;
(
    input  logic       valid_a,
    input  logic       valid_b,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            // On a tie, A wins only if B was the last one served.
            if (valid_a && (!valid_b || last_grant == GRANT_B)) begin
                grant = 2'b01;
            end else if (valid_b) begin
                grant = 2'b10;
            end
        end
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Write-port arbiter in front of register_data. Two requesters (A: I2C target,
// B: internal controller) share one write port with round-robin arbitration.
// A write to any ALL_LED register is forwarded as-is and then replayed into the
// matching byte of every LEDn register, one write per cycle.
// Ports:
//   clk_i, rst_ni                        - clock, synchronous active-low reset
//   a_reg_id_i/a_value_i/a_valid_i       - requester A request
//   a_ready_o                            - requester A accepted this cycle
//   b_reg_id_i/b_value_i/b_valid_i       - requester B request
//   b_ready_o                            - requester B accepted this cycle
//   write_register_id_o/_value_o         - registered write to register_data
//   write_enable_o                       - one-cycle write strobe
//   busy_o                               - ALL_LED fan-out in progress
module register_write_arbiter #(
    parameter int         NUM_CHANNELS = 16,
    parameter logic [7:0] LED_BASE     = 8'h06,
    parameter logic [7:0] ALL_LED_BASE = 8'hFA
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] a_reg_id_i,
    input  logic [7:0] a_value_i,
    input  logic       a_valid_i,
    output logic       a_ready_o,
    input  logic [7:0] b_reg_id_i,
    input  logic [7:0] b_value_i,
    input  logic       b_valid_i,
    output logic       b_ready_o,
    output logic [7:0] write_register_id_o,
    output logic [7:0] write_register_value_o,
    output logic       write_enable_o,
    output logic       busy_o
);
    import pca_regs_pkg::*;

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       off_q;
    logic [7:0]       val_q;
    logic             last_grant_q;
    logic [1:0]       grant;
    logic             idle;
    logic             accept;
    logic             is_bcast;
    logic [7:0]       sel_id;
    logic [7:0]       sel_value;

    rr_grant2 u_grant (
        .valid_a    (a_valid_i),
        .valid_b    (b_valid_i),
        .last_grant (last_grant_q),
        .enable     (idle),
        .grant      (grant)
    );

    assign sel_id    = grant[1] ? b_reg_id_i : a_reg_id_i;
    assign sel_value = grant[1] ? b_value_i  : a_value_i;
    assign accept    = |grant;
    assign is_bcast  = accept && in_all_led(sel_id, ALL_LED_BASE);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (is_bcast) state_d = FANOUT;
            FANOUT:  if (idx_q == IDX_W'(NUM_CHANNELS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        idle      = (state_q == IDLE);
        busy_o    = (state_q == FANOUT);
        a_ready_o = grant[0];
        b_ready_o = grant[1];
    end

    // Write datapath. Accept only happens in IDLE, so the two branches are exclusive.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            write_register_id_o    <= 8'h00;
            write_register_value_o <= 8'h00;
            write_enable_o         <= 1'b0;
            idx_q                  <= '0;
            off_q                  <= 2'd0;
            val_q                  <= 8'h00;
            last_grant_q           <= GRANT_B;
        end else begin
            write_enable_o <= 1'b0;
            if (accept) begin
                write_register_id_o    <= sel_id;
                write_register_value_o <= sel_value;
                write_enable_o         <= 1'b1;
                last_grant_q           <= grant[1];
                if (is_bcast) begin
                    // Byte lane within each LED channel (ON_L/ON_H/OFF_L/OFF_H).
                    off_q <= 2'(sel_id - ALL_LED_BASE);
                    val_q <= sel_value;
                    idx_q <= '0;
                end
            end else if (state_q == FANOUT) begin
                write_register_id_o    <= LED_BASE + 8'(LED_STRIDE) * 8'(idx_q) + 8'(off_q);
                write_register_value_o <= val_q;
                write_enable_o         <= 1'b1;
                idx_q                  <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: doc/register_write_arbiter.md
# register_write_arbiter

Shares the single write port of `register_data` between two write requesters: the I2C target (requester A) and an internal controller such as a software-reset or sleep sequencer (requester B). It uses round-robin arbitration. It also implements ALL_LED broadcast: a write to any ALL_LED register (0xFA–0xFD) is fanned out into the matching byte of every LEDn register. The block sits between the requesters and `register_data`, and drives that block's `write_register_id_i`, `write_register_value_i` and `write_enable_i` inputs.

## Interface
Parameters:
- `NUM_CHANNELS`, 16: number of LED channels in the fan-out.
- `LED_BASE`, 8'h06: register id of LED0_ON_L.
- `ALL_LED_BASE`, 8'hFA: register id of ALL_LED_ON_L.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `a_reg_id_i` in 8: requester A target register.
- `a_value_i` in 8: requester A data.
- `a_valid_i` in 1: requester A write request.
- `a_ready_o` out 1: requester A request accepted this cycle.
- `b_reg_id_i` in 8: requester B target register.
- `b_value_i` in 8: requester B data.
- `b_valid_i` in 1: requester B write request.
- `b_ready_o` out 1: requester B request accepted this cycle.
- `write_register_id_o` out 8: to `register_data`.
- `write_register_value_o` out 8: to `register_data`.
- `write_enable_o` out 1: one-cycle write strobe.
- `busy_o` out 1: high while a fan-out is in progress.

## Operation
- **Handshake:** valid/ready. A request transfers in any cycle where valid and ready are both high. Requesters hold id and value stable until accepted.
- **Ready gating:** `a_ready_o` and `b_ready_o` are combinational. Each is high only in IDLE, when its own valid is high, and when the arbiter grants it. At most one ready is high per cycle.
- **Arbitration:**
  - With one requester valid, that requester is granted.
  - With both valid, the requester not granted most recently is granted.
  - The `last_grant` flop updates on every accepted transfer. It resets to B, so A wins the first tie.
- **States:**
  - IDLE:
    - Accepted id outside 0xFA–0xFD: register outputs id/value and pulse enable; stay in IDLE.
    - Accepted id in 0xFA–0xFD: register outputs with the ALL_LED id itself; latch `off = id - ALL_LED_BASE` (2 bits) and value; set `idx` to 0; go to FANOUT.
  - FANOUT:
    - Each cycle, register a write of the latched value to `LED_BASE + 4*idx + off`, then increment `idx`.
    - When `idx == NUM_CHANNELS-1`, go to IDLE.
    - Requests are not accepted in FANOUT.
- **Arithmetic:** 8-bit modulo, no overflow with default parameters. LED15_OFF_H = 0x45.
- **Non-fan-out ids:** 0xFE (PRE_SCALE), 0xFF, and all other ids are ordinary single writes.
- **Outputs when no write is issued:** `write_enable_o` is 0; id and value hold their last values.
- **Reset values:** all outputs are 0; state IDLE; `idx` 0; `last_grant` B.
- **Reset mid-fan-out:** abort. No further writes are issued and registers already written keep their values.
- **`busy_o`:** high exactly when state is FANOUT.

## Timing
- **Single write:** accepted in cycle T; `write_enable_o` high in T+1 only; latency 1.
- **Throughput:** one single write per cycle. Back-to-back accepts in T and T+1 give strobes in T+1 and T+2.
- **Broadcast write:** accepted in cycle T.
  - ALL_LED register write in T+1.
  - LEDn write in T+2+n (n = 0..15), so LED15 is written in T+17.
  - `busy_o` high T+1..T+16.
  - Ready can next be high in T+17; that next write appears in T+18.
- **Strobe count:** exactly 17 enable pulses per broadcast, on consecutive cycles.

## Structure
- **Shared package `pca_regs_pkg`:**
  - Constants: MODE1=0x00, LED_BASE=0x06, LED_STRIDE=4, ALL_LED_BASE=0xFA, PRE_SCALE=0xFE, NUM_CHANNELS=16.
  - State enum: IDLE, FANOUT.
- **Sub-module `rr_grant2`:** two-input round-robin grant. Inputs: two valids, `last_grant`, and an enable. Output: a one-hot grant.
- **Top-level integration:** `register_write_arbiter` is instantiated between `i2c_target` / the internal controller and `register_data`.

## Test plan
- **Single write:** A writes 0x00←0x11 with B idle → `a_ready_o` in T; enable only in T+1 with id 0x00 and value 0x11; `busy_o` stays 0.
- **Tie-break:** A and B valid simultaneously for three transfers (A: 0x06←0xAA; B: 0x07←0xBB, held valid) → grants A, B, A on consecutive cycles; strobes on consecutive cycles in the same order.
- **Broadcast:** A writes 0xFC←0x5A (ALL_LED_OFF_L) → id 0xFC in T+1, then ids 0x08, 0x0C, …, 0x44 in T+2..T+17, all with value 0x5A; 17 strobes; `b_ready_o` low T+1..T+16 despite `b_valid_i`; B accepted in T+17.
- **Non-fan-out id:** write 0xFE←0x1E → exactly one strobe; no FANOUT.
- **Reset mid-fan-out:** broadcast 0xFD←0x10, then `rst_ni` low in T+6 → from T+7 enable is 0 and all outputs are 0; state IDLE; after release, A wins the first tie.
- **Idle/reset behaviour:** no valids for 20 cycles → no strobes; all outputs remain at reset values.
